// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared constants and the channel-select width helper for tick_gen.
package tick_gen_pkg;

    localparam int unsigned CLK_HZ  = 50_000_000;
    localparam int unsigned HALF_1S = 24_999_999;
    localparam int unsigned HALF_2S = 49_999_999;

    // Channel-select width: at least one bit even for a single channel.
    function automatic int unsigned ch_w(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/tick_gen_ch.sv
// tick_gen_ch: one square-wave channel (half-period register, counter, level and tick strobe).
module tick_gen_ch
    import tick_gen_pkg::*;
#(
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned HALF_INIT = HALF_1S
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             sync,
    input  logic             we,
    input  logic [CNT_W-1:0] wdata,
    output logic             sq_out,
    output logic             tick
);

    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] cnt;

    // Terminal value; a write is used for the compare from the following edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            half <= CNT_W'(HALF_INIT);
        end else if (we) begin
            half <= wdata;
        end
    end

    // Counter, level and strobe; >= lets a shrunk half end the period at the next advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            sq_out <= 1'b0;
            tick   <= 1'b0;
        end else if (sync) begin
            cnt    <= '0;
            sq_out <= 1'b0;
            tick   <= 1'b0;
        end else if (adv) begin
            if (cnt >= half) begin
                cnt    <= '0;
                sq_out <= ~sq_out;
                tick   <= 1'b1;
            end else begin
                cnt    <= cnt + CNT_W'(1);
                tick   <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/tick_gen.sv
// tick_gen: multi-channel programmable square-wave / tick generator.
// Optional shared prescaler enabled by defining TICK_GEN_PRESCALE_EN.
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter  int unsigned CHANNELS  = 2,
    parameter  int unsigned CNT_W     = 32,
    parameter  int unsigned HALF_INIT = 24999999,
    parameter  int unsigned PRESCALE  = 50,
    localparam int unsigned CH_W      = ch_w(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] ch_en,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [CNT_W-1:0]    cfg_half,
    input  logic                sync,
    output logic [CHANNELS-1:0] sq_out,
    output logic [CHANNELS-1:0] tick,
    output logic                cfg_err
);

    // Reject unusable configurations at elaboration.
    if (CHANNELS < 1 || CHANNELS > 16 || PRESCALE < 1) begin : g_param_check
        $error("tick_gen: CHANNELS must be 1..16 and PRESCALE >= 1");
    end

    logic [CHANNELS-1:0] adv_c;
    logic [CHANNELS-1:0] we_c;
    logic                cfg_bad_c;

`ifdef TICK_GEN_PRESCALE_EN
    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0] ps_cnt;
    logic            ps_stb_c;

    assign ps_stb_c = (ps_cnt == PS_W'(PRESCALE - 1));

    // Shared prescaler counting 0..PRESCALE-1; sync restarts it with the channels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_cnt <= '0;
        end else if (sync || ps_stb_c) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + PS_W'(1);
        end
    end

    assign adv_c = ch_en & {CHANNELS{ps_stb_c}};
`else
    assign adv_c = ch_en;
`endif

    // Decode the config write to a one-hot per-channel strobe.
    always_comb begin
        we_c = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            we_c[i] = cfg_we && (32'(cfg_ch) == i);
        end
    end

    assign cfg_bad_c = cfg_we && (32'(cfg_ch) >= CHANNELS);

    // One-cycle error pulse for writes addressed past the last channel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_bad_c;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        tick_gen_ch #(
            .CNT_W     (CNT_W),
            .HALF_INIT (HALF_INIT)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .adv    (adv_c[g]),
            .sync   (sync),
            .we     (we_c[g]),
            .wdata  (cfg_half),
            .sq_out (sq_out[g]),
            .tick   (tick[g])
        );
    end

endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: directed tables, corner sequences and random traffic against a reference model.
`timescale 1ns/1ps
module tb_tick_gen;

    localparam int unsigned NCH   = 3;
    localparam int unsigned CW    = 16;
    localparam int unsigned HINIT = 5;
    localparam int unsigned CHW   = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [NCH-1:0] ch_en = '0;
    logic           cfg_we = 1'b0;
    logic [CHW-1:0] cfg_ch = '0;
    logic [CW-1:0]  cfg_half = '0;
    logic           sync = 1'b0;
    logic [NCH-1:0] sq_out;
    logic [NCH-1:0] tick;
    logic           cfg_err;

    tick_gen #(
        .CHANNELS  (NCH),
        .CNT_W     (CW),
        .HALF_INIT (HINIT),
        .PRESCALE  (50)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ch_en    (ch_en),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_half (cfg_half),
        .sync     (sync),
        .sq_out   (sq_out),
        .tick     (tick),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: advances completed in the current half-period, its length is half+1 advances.
    int m_done [NCH];
    int m_half [NCH];
    bit m_lvl  [NCH];
    bit m_tick [NCH];
    bit m_err;

    typedef struct {
        int ch;
        int half;
        int first;
        int period;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_done[i] = 0;
            m_half[i] = HINIT;
            m_lvl[i]  = 1'b0;
            m_tick[i] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    task automatic model_step();
        m_err = cfg_we && (int'(cfg_ch) >= NCH);
        for (int i = 0; i < NCH; i++) begin
            if (sync) begin
                m_done[i] = 0;
                m_lvl[i]  = 1'b0;
                m_tick[i] = 1'b0;
            end else if (ch_en[i]) begin
                if (m_done[i] + 1 >= m_half[i] + 1) begin
                    m_done[i] = 0;
                    m_lvl[i]  = !m_lvl[i];
                    m_tick[i] = 1'b1;
                end else begin
                    m_done[i] = m_done[i] + 1;
                    m_tick[i] = 1'b0;
                end
            end else begin
                m_tick[i] = 1'b0;
            end
            if (cfg_we && int'(cfg_ch) == i) m_half[i] = int'(cfg_half);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < NCH; i++) begin
            check($sformatf("model sq_out[%0d]", i), int'(sq_out[i]), int'(m_lvl[i]));
            check($sformatf("model tick[%0d]", i), int'(tick[i]), int'(m_tick[i]));
        end
        check("model cfg_err", int'(cfg_err), int'(m_err));
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
        compare_all();
    endtask

    // Cycles until sq_out[ch] reaches lvl, bounded.
    task automatic wait_lvl(input int ch, input bit lvl, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (sq_out[ch] !== lvl && n < 64);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, a, b, r0, r1;

        vecs[0] = '{ch: 0, half: 3, first: 4, period: 8};
        vecs[1] = '{ch: 1, half: 0, first: 1, period: 2};
        vecs[2] = '{ch: 2, half: 6, first: 7, period: 14};
        vecs[3] = '{ch: 0, half: 1, first: 2, period: 4};

        // Reset state and the HALF_INIT period after release.
        model_reset();
        ch_en = '1;
        #12;
        compare_all();
        check("reset sq_out", int'(sq_out), 0);
        rst = 1'b1;
        wait_lvl(0, 1'b1, n);  check("init first rise", n, HINIT + 1);
        wait_lvl(0, 1'b0, n);  check("init first fall", n, HINIT + 1);
        wait_lvl(0, 1'b1, n);
        cycle();
        cycle();
        check("pre-reset sq_out[0]", int'(sq_out[0]), 1);

        // Asynchronous reset mid-count, checked before any clock edge.
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("async sq_out", int'(sq_out), 0);
        check("async tick", int'(tick), 0);
        compare_all();
        #2 rst = 1'b1;
        wait_lvl(0, 1'b1, n);  check("post-reset rise", n, HINIT + 1);
        wait_lvl(0, 1'b0, n);  check("post-reset fall", n, HINIT + 1);

        // Period table: write with sync, then measure first rise and full period.
        for (int v = 0; v < 4; v++) begin
            cfg_we = 1'b1; cfg_ch = CHW'(vecs[v].ch); cfg_half = CW'(vecs[v].half); sync = 1'b1;
            cycle();
            cfg_we = 1'b0; sync = 1'b0;
            wait_lvl(vecs[v].ch, 1'b1, n);
            check($sformatf("vec%0d first rise", v), n, vecs[v].first);
            wait_lvl(vecs[v].ch, 1'b0, a);
            wait_lvl(vecs[v].ch, 1'b1, b);
            check($sformatf("vec%0d period", v), a + b, vecs[v].period);
        end

        // H=0 keeps tick high continuously.
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("h0 tick[1]", int'(tick[1]), 1);
        end

        // Shrink half mid-count: terminate at the next advance, no wrap.
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_half = CW'(9); sync = 1'b1;
        cycle();
        cfg_we = 1'b0; sync = 1'b0;
        repeat (7) cycle();
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_half = CW'(4);
        cycle();
        cfg_we = 1'b0;
        check("shrink write edge sq", int'(sq_out[0]), 0);
        cycle();
        check("shrink toggle sq", int'(sq_out[0]), 1);
        check("shrink toggle tick", int'(tick[0]), 1);
        wait_lvl(0, 1'b0, n);  check("shrink half 1", n, 5);
        wait_lvl(0, 1'b1, n);  check("shrink half 2", n, 5);

        // Disable for 5 cycles mid half-period: stretches to 9.
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_half = CW'(3); sync = 1'b1;
        cycle();
        cfg_we = 1'b0; sync = 1'b0;
        repeat (2) cycle();
        ch_en[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("disabled tick[0]", int'(tick[0]), 0);
        end
        ch_en[0] = 1'b1;
        wait_lvl(0, 1'b1, n);
        check("stretched half", 7 + n, 9);

        // Sync mid-count restarts channels in phase.
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_half = CW'(5);
        cycle();
        cfg_we = 1'b0;
        repeat (7) cycle();
        sync = 1'b1;
        cycle();
        sync = 1'b0;
        check("sync sq_out", int'(sq_out), 0);
        r0 = 0; r1 = 0;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            if (r0 == 0 && sq_out[0]) r0 = k;
            if (r1 == 0 && sq_out[1]) r1 = k;
        end
        check("sync ch0 rise", r0, 4);
        check("sync ch1 rise", r1, 6);

        // Out-of-range write: one-cycle error, periods untouched.
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_half = CW'(7);
        cycle();
        cfg_we = 1'b0;
        check("cfg_err pulse", int'(cfg_err), 1);
        cycle();
        check("cfg_err clear", int'(cfg_err), 0);
        sync = 1'b1;
        cycle();
        sync = 1'b0;
        wait_lvl(0, 1'b1, n);  check("after bad write ch0 rise", n, 4);
        wait_lvl(0, 1'b0, a);
        wait_lvl(0, 1'b1, b);
        check("after bad write ch0 period", a + b, 8);

        // Random traffic against the model.
        for (int k = 0; k < 2000; k++) begin
            ch_en    = NCH'($urandom);
            cfg_we   = ($urandom_range(0, 9) == 0);
            cfg_ch   = CHW'($urandom_range(0, 3));
            cfg_half = CW'($urandom_range(0, 7));
            sync     = ($urandom_range(0, 49) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
